// File: rtl/sa_ctrl_axil_slave_if.sv
// AXI4-Lite bus bundle between the host-side master and the engine control slave.
// Signal names follow the AXI4-Lite channel naming used on the slave's ports.
interface sa_ctrl_axil_slave_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;

  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;

  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;

  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;

  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/sa_ctrl_axil_slave.sv
// AXI4-Lite control/status register block for the systolic-array engine:
// CONTROL (start), READ_BASE, WRITE_BASE and STATUS (done / busy / start error).
module sa_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  sa_ctrl_axil_slave_if.slave           axi,
  output logic                          start_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] read_base_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] write_base_o,
  input  logic                          busy_i,
  input  logic                          done_i
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int WW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [WW-1:0] IDX_CONTROL    = WW'(0);
  localparam logic [WW-1:0] IDX_READ_BASE  = WW'(1);
  localparam logic [WW-1:0] IDX_WRITE_BASE = WW'(2);
  localparam logic [WW-1:0] IDX_STATUS     = WW'(3);

  logic          ready_en;
  logic          aw_held;
  logic [WW-1:0] aw_word;
  logic          w_held;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          bvalid;
  logic [1:0]    bresp;
  logic          rvalid;
  logic [1:0]    rresp;
  logic [DW-1:0] rdata;

  logic          ctrl_start;
  logic [DW-1:0] read_base;
  logic [DW-1:0] write_base;
  logic          st_done;
  logic          st_start_err;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          do_write;
  logic [WW-1:0] wr_word;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_mapped;
  logic          start_fire;
  logic          start_reject;
  logic          w1c_done;
  logic          w1c_err;
  logic [WW-1:0] rd_word;
  logic [DW-1:0] rd_value;
  logic          unused_ok;

  // Ready flags come up only after the first clock edge out of reset.
  assign axi.S_AXI_AWREADY = ready_en & ~aw_held & ~bvalid;
  assign axi.S_AXI_WREADY  = ready_en & ~w_held & ~bvalid;
  assign axi.S_AXI_ARREADY = ready_en & ~rvalid;
  assign axi.S_AXI_BVALID  = bvalid;
  assign axi.S_AXI_BRESP   = bresp;
  assign axi.S_AXI_RVALID  = rvalid;
  assign axi.S_AXI_RRESP   = rresp;
  assign axi.S_AXI_RDATA   = rdata;

  assign read_base_o  = read_base;
  assign write_base_o = write_base;

  assign aw_hs = axi.S_AXI_AWVALID & axi.S_AXI_AWREADY;
  assign w_hs  = axi.S_AXI_WVALID & axi.S_AXI_WREADY;
  assign ar_hs = axi.S_AXI_ARVALID & axi.S_AXI_ARREADY;

  // A write commits as soon as both halves are available, whether held or handshaking now.
  assign do_write  = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid;
  assign wr_word   = aw_held ? aw_word : axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data   = w_held ? w_data : axi.S_AXI_WDATA;
  assign wr_strb   = w_held ? w_strb : axi.S_AXI_WSTRB;
  assign wr_mapped = (wr_word <= IDX_STATUS);

  assign start_fire   = do_write & (wr_word == IDX_CONTROL) & wr_strb[0] & wr_data[0] & ~busy_i;
  assign start_reject = do_write & (wr_word == IDX_CONTROL) & wr_strb[0] & wr_data[0] & busy_i;
  assign w1c_done     = do_write & (wr_word == IDX_STATUS) & wr_strb[0] & wr_data[0];
  assign w1c_err      = do_write & (wr_word == IDX_STATUS) & wr_strb[0] & wr_data[2];

  assign rd_word = axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  assign unused_ok = ^{axi.S_AXI_AWPROT, axi.S_AXI_ARPROT,
                       axi.S_AXI_AWADDR[1:0], axi.S_AXI_ARADDR[1:0]};

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_val,
                                                input logic [DW-1:0] new_val,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] result;
    result = old_val;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) result[8*i +: 8] = new_val[8*i +: 8];
    end
    return result;
  endfunction

  always_comb begin
    rd_value = '0;
    case (rd_word)
      IDX_CONTROL:    rd_value = DW'(ctrl_start);
      IDX_READ_BASE:  rd_value = read_base;
      IDX_WRITE_BASE: rd_value = write_base;
      IDX_STATUS:     rd_value = DW'({st_start_err, busy_i, st_done});
      default:        rd_value = '0;
    endcase
  end

  // Write channel: capture AW and W independently, then issue one response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      aw_word  <= '0;
      w_held   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_word <= axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= axi.S_AXI_WDATA;
          w_strb <= axi.S_AXI_WSTRB;
        end
        if (bvalid && axi.S_AXI_BREADY) bvalid <= 1'b0;
      end
    end
  end

  // Register file; engine events (done_i, rejected start) win over W1C clears.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      start_o      <= 1'b0;
      ctrl_start   <= 1'b0;
      read_base    <= '0;
      write_base   <= '0;
      st_done      <= 1'b0;
      st_start_err <= 1'b0;
    end else begin
      start_o <= start_fire;
      if (do_write && wr_word == IDX_CONTROL && wr_strb[0]) ctrl_start <= wr_data[0];
      if (do_write && wr_word == IDX_READ_BASE)
        read_base <= merge_lanes(read_base, wr_data, wr_strb);
      if (do_write && wr_word == IDX_WRITE_BASE)
        write_base <= merge_lanes(write_base, wr_data, wr_strb);
      if (done_i)                    st_done <= 1'b1;
      else if (start_fire || w1c_done) st_done <= 1'b0;
      if (start_reject)              st_start_err <= 1'b1;
      else if (w1c_err)              st_start_err <= 1'b0;
    end
  end

  // Read channel samples registers before any same-cycle write lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= (rd_word <= IDX_STATUS) ? RESP_OKAY : RESP_SLVERR;
      rdata  <= rd_value;
    end else if (rvalid && axi.S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sa_ctrl_axil_slave.sv
// Directed bench for sa_ctrl_axil_slave; read results go through an expectation queue
// that is filled when a read is issued and drained when RVALID appears.
module tb_sa_ctrl_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_o;
  logic [31:0] read_base_o;
  logic [31:0] write_base_o;
  logic        busy_i = 1'b0;
  logic        done_i = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int start_count = 0;

  logic [33:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  sa_ctrl_axil_slave_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) axi ();

  sa_ctrl_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .axi         (axi),
    .start_o     (start_o),
    .read_base_o (read_base_o),
    .write_base_o(write_base_o),
    .busy_i      (busy_i),
    .done_i      (done_i)
  );

  always @(negedge clk) if (start_o === 1'b1) start_count++;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input int exp_starts);
    int   s0;
    int   cycles;
    logic aw_done;
    logic w_done;
    logic start_at_rise;
    s0 = start_count;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_WVALID  = 1'b1;
    cycles = 0;
    while ((axi.S_AXI_AWVALID || axi.S_AXI_WVALID) && cycles < 20) begin
      aw_done = axi.S_AXI_AWVALID & axi.S_AXI_AWREADY;
      w_done  = axi.S_AXI_WVALID & axi.S_AXI_WREADY;
      tick();
      if (aw_done) axi.S_AXI_AWVALID = 1'b0;
      if (w_done)  axi.S_AXI_WVALID  = 1'b0;
      cycles++;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    cycles = 0;
    while (axi.S_AXI_BVALID !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check_output({tag, "_bvalid"}, 32'(axi.S_AXI_BVALID), 32'd1);
    start_at_rise = start_o;
    check_output({tag, "_bresp"}, 32'(axi.S_AXI_BRESP), 32'(exp_resp));
    axi.S_AXI_BREADY = 1'b1;
    tick();
    axi.S_AXI_BREADY = 1'b0;
    check_output({tag, "_bdone"}, 32'(axi.S_AXI_BVALID), 32'd0);
    tick();
    check_output({tag, "_starts"}, 32'(start_count - s0), 32'(exp_starts));
    check_output({tag, "_start_at_b"}, 32'(start_at_rise), 32'(exp_starts > 0));
  endtask

  task automatic axi_read(input string tag, input logic [5:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int          cycles;
    logic        ar_done;
    logic [33:0] expected;
    string       etag;
    exp_q.push_back({exp_resp, exp_data});
    tag_q.push_back(tag);
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    cycles = 0;
    while (axi.S_AXI_ARVALID && cycles < 20) begin
      ar_done = axi.S_AXI_ARVALID & axi.S_AXI_ARREADY;
      tick();
      if (ar_done) axi.S_AXI_ARVALID = 1'b0;
      cycles++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    cycles = 0;
    while (axi.S_AXI_RVALID !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check_output({tag, "_rvalid"}, 32'(axi.S_AXI_RVALID), 32'd1);
    expected = exp_q.pop_front();
    etag = tag_q.pop_front();
    check_output({etag, "_rdata"}, axi.S_AXI_RDATA, expected[31:0]);
    check_output({etag, "_rresp"}, 32'(axi.S_AXI_RRESP), 32'(expected[33:32]));
    axi.S_AXI_RREADY = 1'b1;
    tick();
    axi.S_AXI_RREADY = 1'b0;
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWPROT  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARPROT  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;

    // Reset state
    repeat (3) tick();
    check_output("rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    check_output("rst_wready", 32'(axi.S_AXI_WREADY), 32'd0);
    check_output("rst_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
    check_output("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check_output("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    check_output("rst_start", 32'(start_o), 32'd0);
    check_output("rst_rbase", read_base_o, 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("rel_awready_before_edge", 32'(axi.S_AXI_AWREADY), 32'd0);
    tick();
    check_output("rel_awready_after_edge", 32'(axi.S_AXI_AWREADY), 32'd1);
    check_output("rel_arready_after_edge", 32'(axi.S_AXI_ARREADY), 32'd1);

    // Base registers
    axi_write("wr_rbase", 6'h04, 32'h0000_0000, 4'hF, 2'b00, 0);
    axi_write("wr_wbase", 6'h08, 32'h0000_0400, 4'hF, 2'b00, 0);
    axi_read("rd_rbase", 6'h04, 32'h0000_0000, 2'b00);
    axi_read("rd_wbase", 6'h08, 32'h0000_0400, 2'b00);
    check_output("out_rbase", read_base_o, 32'h0000_0000);
    check_output("out_wbase", write_base_o, 32'h0000_0400);

    // Start pulse
    axi_write("start1", 6'h00, 32'h1, 4'hF, 2'b00, 1);
    axi_write("start0", 6'h00, 32'h0, 4'hF, 2'b00, 0);
    axi_read("rd_ctrl0", 6'h00, 32'h0, 2'b00);

    // DONE sticky, W1C, and set-wins
    pulse_done();
    axi_read("rd_done1", 6'h0C, 32'h1, 2'b00);
    axi_write("w1c_done", 6'h0C, 32'h1, 4'hF, 2'b00, 0);
    axi_read("rd_done0", 6'h0C, 32'h0, 2'b00);
    axi.S_AXI_AWADDR  = 6'h0C;
    axi.S_AXI_WDATA   = 32'h1;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    done_i = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    done_i = 1'b0;
    check_output("coinc_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
    axi.S_AXI_BREADY = 1'b1;
    tick();
    axi.S_AXI_BREADY = 1'b0;
    axi_read("rd_done_setwins", 6'h0C, 32'h1, 2'b00);
    axi_write("w1c_done2", 6'h0C, 32'h1, 4'hF, 2'b00, 0);

    // Start while busy
    busy_i = 1'b1;
    axi_write("start_busy", 6'h00, 32'h1, 4'hF, 2'b00, 0);
    axi_read("rd_status_err", 6'h0C, 32'h6, 2'b00);
    axi_read("rd_ctrl_level", 6'h00, 32'h1, 2'b00);
    axi_write("w1c_err", 6'h0C, 32'h4, 4'hF, 2'b00, 0);
    axi_read("rd_status_busy", 6'h0C, 32'h2, 2'b00);
    busy_i = 1'b0;
    axi_read("rd_status_idle", 6'h0C, 32'h0, 2'b00);

    // W leads AW by three cycles, partial strobes
    axi.S_AXI_WDATA  = 32'hAABB_CCDD;
    axi.S_AXI_WSTRB  = 4'b0011;
    axi.S_AXI_WVALID = 1'b1;
    check_output("early_wready", 32'(axi.S_AXI_WREADY), 32'd1);
    tick();
    axi.S_AXI_WVALID = 1'b0;
    tick();
    tick();
    check_output("early_no_b", 32'(axi.S_AXI_BVALID), 32'd0);
    axi.S_AXI_AWADDR  = 6'h08;
    axi.S_AXI_AWVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    check_output("late_aw_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
    check_output("late_aw_bresp", 32'(axi.S_AXI_BRESP), 32'd0);
    axi.S_AXI_BREADY = 1'b1;
    tick();
    axi.S_AXI_BREADY = 1'b0;
    tick();
    check_output("late_aw_single_b", 32'(axi.S_AXI_BVALID), 32'd0);
    check_output("out_wbase_strb", write_base_o, 32'h0000_CCDD);
    axi_read("rd_wbase_strb", 6'h08, 32'h0000_CCDD, 2'b00);
    axi_read("rd_wbase_unaligned", 6'h0B, 32'h0000_CCDD, 2'b00);

    // Unmapped space
    axi_write("wr_unmapped", 6'h20, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
    axi_read("rd_unmapped", 6'h20, 32'h0, 2'b10);
    check_output("unmapped_no_side_effect", write_base_o, 32'h0000_CCDD);

    // Reset during a half-accepted write
    axi_write("wr_rbase_pre_rst", 6'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
    axi.S_AXI_AWADDR  = 6'h04;
    axi.S_AXI_AWVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    check_output("midwr_aw_held", 32'(axi.S_AXI_AWREADY), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check_output("midrst_rbase", read_base_o, 32'd0);
    check_output("midrst_wbase", write_base_o, 32'd0);
    check_output("midrst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_output("postrst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    axi_read("postrst_ctrl", 6'h00, 32'h0, 2'b00);
    axi_read("postrst_rbase", 6'h04, 32'h0, 2'b00);
    axi_read("postrst_wbase", 6'h08, 32'h0, 2'b00);
    axi_read("postrst_status", 6'h0C, 32'h0, 2'b00);
    axi_write("postrst_wr", 6'h04, 32'h1234_5678, 4'hF, 2'b00, 0);
    axi_read("postrst_rd", 6'h04, 32'h1234_5678, 2'b00);
    check_output("postrst_out_rbase", read_base_o, 32'h1234_5678);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
